// File: rtl/sub32_sequential.sv
// Multi-cycle subtractor: a_i - b_i one chunk per cycle, LSB chunk first, with a registered ripple borrow.
// Optional macro SUB_SIGNED_OVF_EN adds the overflow_o port (signed overflow flag, valid with done_o).
module sub32_sequential #(
    parameter int nb_bits    = 32,
    parameter int chunk_bits = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [nb_bits-1:0] a_i,
    input  logic [nb_bits-1:0] b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [nb_bits-1:0] diff_o,
    output logic               borrow_o
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic               overflow_o
`endif
);

    localparam int NCHUNK = nb_bits / chunk_bits;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if (nb_bits % chunk_bits != 0) begin : g_chunk_check
        $error("sub32_sequential: nb_bits must be a multiple of chunk_bits");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [NCHUNK-1:0][chunk_bits-1:0] a_q, b_q, diff_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic                              borrow_q;
    logic [chunk_bits:0]               sub_d;
    logic                              accept;
    logic                              last_chunk;

    assign accept     = (state_q == IDLE) && start_i;
    assign last_chunk = (state_q == RUN) && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == RUN) || (state_q == DONE);
        done_o = (state_q == DONE);
    end

    // Extra top bit of the chunk-wide difference is the borrow out of this chunk.
    always_comb begin
        sub_d = {1'b0, a_q[cnt_q]} - {1'b0, b_q[cnt_q]} - {{chunk_bits{1'b0}}, borrow_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_q      <= a_i;
            b_q      <= b_i;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else if (state_q == RUN) begin
            diff_q[cnt_q] <= sub_d[chunk_bits-1:0];
            borrow_q      <= sub_d[chunk_bits];
            cnt_q         <= cnt_q + CNT_W'(1);
        end
    end

    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_q;

    // Captured as the MSB chunk completes, so it is high only during DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (last_chunk) begin
            ovf_q <= (a_q[NCHUNK-1][chunk_bits-1] != b_q[NCHUNK-1][chunk_bits-1]) &&
                     (sub_d[chunk_bits-1] != a_q[NCHUNK-1][chunk_bits-1]);
        end else begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow_o = ovf_q;
`else
    logic unused_last;
    assign unused_last = last_chunk;
`endif

endmodule

// File: tb/tb_sub32_sequential.sv
// Self-checking bench for sub32_sequential: vector table plus multi-cycle handshake/reset sequences.
module tb_sub32_sequential;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o, borrow_o;
    logic [31:0] diff_o;
    logic        overflow_s;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    sub32_sequential dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .diff_o   (diff_o),
        .borrow_o (borrow_o)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .overflow_o (overflow_s)
`endif
    );

`ifndef SUB_SIGNED_OVF_EN
    assign overflow_s = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        borrow;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done_o; lat counts rising edges since the edge that sampled start_i.
    task automatic wait_done(inout int lat, output logic [31:0] d, output logic br, output logic ov);
        while (!done_o && lat < 30) begin
            @(negedge clk_i);
            lat++;
        end
        if (!done_o) lat = -1;
        d  = diff_o;
        br = borrow_o;
        ov = overflow_s;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] d, output logic br, output logic ov, output int lat);
        @(negedge clk_i);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(negedge clk_i);
        start_i = 1'b0;
        lat     = 1;
        wait_done(lat, d, br, ov);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (done_o) n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        br, ov;
        int          lat, n;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1};
        vecs[3] = '{32'd87654321,  32'd12345678,  32'd75308643,  1'b0};
        vecs[4] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'h0100_0000, 32'h00FF_FFFF, 32'h0000_0001, 1'b0};

        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        rst_ni  = 1'b0;
        #1;
        check("reset_busy",   {31'd0, busy_o},   32'd0);
        check("reset_done",   {31'd0, done_o},   32'd0);
        check("reset_diff",   diff_o,            32'd0);
        check("reset_borrow", {31'd0, borrow_o}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, d, br, ov, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd5);
            check($sformatf("vec%0d_diff", i), d, vecs[i].diff);
            check($sformatf("vec%0d_borrow", i), {31'd0, br}, {31'd0, vecs[i].borrow});
            @(negedge clk_i);
            check($sformatf("vec%0d_done_pulse", i), {30'd0, done_o, busy_o}, 32'd0);
            check($sformatf("vec%0d_hold", i), diff_o, vecs[i].diff);
        end

        // Start pulsed mid-RUN with different operands, operands left changed afterwards.
        @(negedge clk_i);
        start_i = 1'b1;
        a_i     = 32'd87654321;
        b_i     = 32'd12345678;
        @(negedge clk_i);
        start_i = 1'b0;
        check("midrun_busy", {31'd0, busy_o}, 32'd1);
        @(negedge clk_i);
        start_i = 1'b1;
        a_i     = 32'h0000_0001;
        b_i     = 32'h0000_0002;
        @(negedge clk_i);
        start_i = 1'b0;
        lat     = 3;
        wait_done(lat, d, br, ov);
        check("midrun_latency", lat, 32'd5);
        check("midrun_diff", d, 32'd75308643);
        check("midrun_borrow", {31'd0, br}, 32'd0);
        count_dones(8, n);
        check("midrun_no_extra_done", n, 32'd0);

        // Held start: re-trigger right after DONE, one result per 6 cycles.
        @(negedge clk_i);
        start_i = 1'b1;
        a_i     = 32'd10;
        b_i     = 32'd3;
        @(negedge clk_i);
        lat = 1;
        wait_done(lat, d, br, ov);
        check("held_first_latency", lat, 32'd5);
        check("held_first_diff", d, 32'd7);
        a_i = 32'd3;
        b_i = 32'd10;
        @(negedge clk_i);
        lat = 1;
        wait_done(lat, d, br, ov);
        start_i = 1'b0;
        check("held_gap", lat, 32'd6);
        check("held_second_diff", d, 32'hFFFF_FFF9);
        check("held_second_borrow", {31'd0, br}, 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);

        // Reset asserted two cycles into an operation.
        @(negedge clk_i);
        start_i = 1'b1;
        a_i     = 32'h0000_0005;
        b_i     = 32'h0000_0007;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("abort_busy",   {31'd0, busy_o},   32'd0);
        check("abort_done",   {31'd0, done_o},   32'd0);
        check("abort_diff",   diff_o,            32'd0);
        check("abort_borrow", {31'd0, borrow_o}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        count_dones(8, n);
        check("abort_no_done", n, 32'd0);
        run_op(32'h0000_0009, 32'h0000_0004, d, br, ov, lat);
        check("after_abort_latency", lat, 32'd5);
        check("after_abort_diff", d, 32'd5);
        check("after_abort_borrow", {31'd0, br}, 32'd0);

`ifdef SUB_SIGNED_OVF_EN
        run_op(32'h8000_0000, 32'h0000_0001, d, br, ov, lat);
        check("ovf1_diff", d, 32'h7FFF_FFFF);
        check("ovf1_overflow", {31'd0, ov}, 32'd1);
        check("ovf1_borrow", {31'd0, br}, 32'd0);
        @(negedge clk_i);
        check("ovf1_cleared", {31'd0, overflow_s}, 32'd0);
        run_op(32'h0000_0001, 32'h0000_0002, d, br, ov, lat);
        check("ovf2_overflow", {31'd0, ov}, 32'd0);
        check("ovf2_borrow", {31'd0, br}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
